// File: rtl/matrix_store_pkg.sv
// Shared types and the slot address mapping for the matrix slot store.
package matrix_store_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WR_STREAM = 2'd1,
        ST_RD_STREAM = 2'd2,
        ST_RD_DRAIN  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_DIM   = 2'd1,
        ERR_EMPTY = 2'd2,
        ERR_RANGE = 2'd3
    } err_code_t;

    // Each slot owns a contiguous block of block_size elements.
    function automatic logic [31:0] slot_addr(input logic [31:0] slot,
                                              input logic [31:0] idx,
                                              input logic [31:0] block_size);
        return slot * block_size + idx;
    endfunction

endpackage

// File: rtl/matrix_store_ram.sv
// Single-port block RAM with registered read (one cycle latency, read-first).
module matrix_store_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
        rdata_o <= mem[addr_i];
    end

endmodule

// File: rtl/matrix_slot_store.sv
// Slot-based matrix store: per-slot metadata and valid bitmap, streamed writes,
// and reads delivered through a two-entry output buffer with backpressure.
module matrix_slot_store
    import matrix_store_pkg::*;
#(
    parameter int NUM_SLOTS  = 8,
    parameter int BLOCK_SIZE = 1152,
    parameter int DATA_WIDTH = 32,
    parameter int DIM_WIDTH  = 8,
    parameter int NAME_WIDTH = 64,
    parameter int SLOT_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
    parameter int ADDR_WIDTH = $clog2(NUM_SLOTS * BLOCK_SIZE),
    parameter int CNT_W      = $clog2(BLOCK_SIZE + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_req,
    input  logic [SLOT_W-1:0]     clr_slot,
    input  logic                  wr_req,
    input  logic [SLOT_W-1:0]     wr_slot,
    input  logic [DIM_WIDTH-1:0]  wr_rows,
    input  logic [DIM_WIDTH-1:0]  wr_cols,
    input  logic [NAME_WIDTH-1:0] wr_name,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic                  wr_done,
    input  logic                  rd_req,
    input  logic [SLOT_W-1:0]     rd_slot,
    output logic                  rd_meta_valid,
    output logic [DIM_WIDTH-1:0]  rd_rows,
    output logic [DIM_WIDTH-1:0]  rd_cols,
    output logic [NAME_WIDTH-1:0] rd_name,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  rd_last,
    output logic                  rd_done,
    output logic                  err,
    output logic [1:0]            err_code,
    output logic [NUM_SLOTS-1:0]  slot_valid,
    output logic                  idle
);

    localparam int              PROD_W      = 2 * DIM_WIDTH;
    localparam logic [SLOT_W:0] SLOT_LIMIT  = (SLOT_W + 1)'(NUM_SLOTS);
    localparam logic [31:0]     BLOCK_LIMIT = BLOCK_SIZE;

    state_t                  state_q;
    logic [SLOT_W-1:0]       slot_q;
    logic [CNT_W-1:0]        total_q;
    logic [CNT_W-1:0]        idx_q;
    logic [NUM_SLOTS-1:0]    slot_valid_q;
    logic [DIM_WIDTH-1:0]    meta_rows_q [NUM_SLOTS];
    logic [DIM_WIDTH-1:0]    meta_cols_q [NUM_SLOTS];
    logic [NAME_WIDTH-1:0]   meta_name_q [NUM_SLOTS];

    logic                    wr_ready_q, wr_done_q, rd_done_q, rd_meta_valid_q;
    logic                    err_q;
    err_code_t               err_code_q;
    logic [DIM_WIDTH-1:0]    rd_rows_q, rd_cols_q;
    logic [NAME_WIDTH-1:0]   rd_name_q;

    // Output buffer: head register drives the port, skid entry absorbs the
    // element that was already in flight from the RAM when the consumer stalled.
    logic [DATA_WIDTH-1:0]   rd_data_q, sk_data_q;
    logic                    rd_valid_q, rd_last_q, sk_valid_q, sk_last_q;
    logic                    rv_q, rv_last_q;

    logic                    ram_we;
    logic [ADDR_WIDTH-1:0]   ram_addr;
    logic [DATA_WIDTH-1:0]   ram_rdata;

    logic                    is_idle, accept_clr, accept_wr, accept_rd;
    logic                    clr_range_bad, wr_range_bad, rd_range_bad;
    logic                    wr_dim_bad, rd_empty, wr_start, rd_start;
    logic [PROD_W-1:0]       wr_prod, rd_prod;
    logic [31:0]             wr_prod_ext;
    logic [CNT_W-1:0]        rd_total;
    logic                    pop, can_issue, rd_issue, issue_last, wr_fire;
    logic [1:0]              occ;
    logic [SLOT_W-1:0]       issue_slot;
    logic [CNT_W-1:0]        issue_idx;

    assign is_idle       = (state_q == ST_IDLE);
    assign accept_clr    = is_idle & clr_req;
    assign accept_wr     = is_idle & ~clr_req & wr_req;
    assign accept_rd     = is_idle & ~clr_req & ~wr_req & rd_req;

    assign clr_range_bad = ({1'b0, clr_slot} >= SLOT_LIMIT);
    assign wr_range_bad  = ({1'b0, wr_slot} >= SLOT_LIMIT);
    assign rd_range_bad  = ({1'b0, rd_slot} >= SLOT_LIMIT);

    assign wr_prod       = PROD_W'(wr_rows) * PROD_W'(wr_cols);
    assign wr_prod_ext   = 32'(wr_prod);
    assign wr_dim_bad    = (wr_rows == '0) || (wr_cols == '0) || (wr_prod_ext > BLOCK_LIMIT);
    assign rd_empty      = ~slot_valid_q[rd_slot];
    assign rd_prod       = PROD_W'(meta_rows_q[rd_slot]) * PROD_W'(meta_cols_q[rd_slot]);
    assign rd_total      = CNT_W'(rd_prod);

    assign wr_start      = accept_wr & ~wr_range_bad & ~wr_dim_bad;
    assign rd_start      = accept_rd & ~rd_range_bad & ~rd_empty;
    assign wr_fire       = (state_q == ST_WR_STREAM) & wr_valid & wr_ready_q;

    // Issue only if the element can be parked even if the consumer stalls next cycle.
    assign pop           = rd_valid_q & rd_ready;
    assign occ           = {1'b0, rd_valid_q} + {1'b0, sk_valid_q};
    assign can_issue     = (occ + {1'b0, rv_q}) <= (2'd1 + {1'b0, pop});
    assign rd_issue      = rd_start | ((state_q == ST_RD_STREAM) & can_issue);
    assign issue_slot    = rd_start ? rd_slot : slot_q;
    assign issue_idx     = rd_start ? '0 : idx_q;
    assign issue_last    = rd_start ? (rd_total == CNT_W'(1)) : (idx_q + CNT_W'(1) == total_q);

    always_comb begin
        ram_we   = 1'b0;
        ram_addr = '0;
        if (wr_fire) begin
            ram_we   = 1'b1;
            ram_addr = ADDR_WIDTH'(slot_addr(32'(slot_q), 32'(idx_q), BLOCK_LIMIT));
        end else if (rd_issue) begin
            ram_addr = ADDR_WIDTH'(slot_addr(32'(issue_slot), 32'(issue_idx), BLOCK_LIMIT));
        end
    end

    matrix_store_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (NUM_SLOTS * BLOCK_SIZE),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (wr_data),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rv_q       <= 1'b0;
            rv_last_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            rd_data_q  <= '0;
            sk_valid_q <= 1'b0;
            sk_last_q  <= 1'b0;
            sk_data_q  <= '0;
        end else begin
            rv_q      <= rd_issue;
            rv_last_q <= rd_issue & issue_last;
            if (!rd_valid_q || pop) begin
                if (sk_valid_q) begin
                    rd_data_q  <= sk_data_q;
                    rd_last_q  <= sk_last_q;
                    rd_valid_q <= 1'b1;
                    sk_valid_q <= rv_q;
                    sk_data_q  <= ram_rdata;
                    sk_last_q  <= rv_last_q;
                end else if (rv_q) begin
                    rd_data_q  <= ram_rdata;
                    rd_last_q  <= rv_last_q;
                    rd_valid_q <= 1'b1;
                end else begin
                    rd_valid_q <= 1'b0;
                    rd_last_q  <= 1'b0;
                end
            end else if (rv_q) begin
                sk_valid_q <= 1'b1;
                sk_data_q  <= ram_rdata;
                sk_last_q  <= rv_last_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            slot_q          <= '0;
            total_q         <= '0;
            idx_q           <= '0;
            slot_valid_q    <= '0;
            wr_ready_q      <= 1'b0;
            wr_done_q       <= 1'b0;
            rd_done_q       <= 1'b0;
            rd_meta_valid_q <= 1'b0;
            err_q           <= 1'b0;
            err_code_q      <= ERR_NONE;
            rd_rows_q       <= '0;
            rd_cols_q       <= '0;
            rd_name_q       <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                meta_rows_q[i] <= '0;
                meta_cols_q[i] <= '0;
                meta_name_q[i] <= '0;
            end
        end else begin
            err_q           <= 1'b0;
            wr_done_q       <= 1'b0;
            rd_done_q       <= 1'b0;
            rd_meta_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept_clr) begin
                        if (clr_range_bad) begin
                            err_q      <= 1'b1;
                            err_code_q <= ERR_RANGE;
                        end else begin
                            slot_valid_q[clr_slot] <= 1'b0;
                        end
                    end else if (accept_wr) begin
                        if (wr_range_bad) begin
                            err_q      <= 1'b1;
                            err_code_q <= ERR_RANGE;
                        end else if (wr_dim_bad) begin
                            err_q      <= 1'b1;
                            err_code_q <= ERR_DIM;
                        end else begin
                            meta_rows_q[wr_slot]  <= wr_rows;
                            meta_cols_q[wr_slot]  <= wr_cols;
                            meta_name_q[wr_slot]  <= wr_name;
                            slot_valid_q[wr_slot] <= 1'b0;
                            slot_q                <= wr_slot;
                            total_q               <= CNT_W'(wr_prod);
                            idx_q                 <= '0;
                            wr_ready_q            <= 1'b1;
                            state_q               <= ST_WR_STREAM;
                        end
                    end else if (accept_rd) begin
                        if (rd_range_bad) begin
                            err_q      <= 1'b1;
                            err_code_q <= ERR_RANGE;
                        end else if (rd_empty) begin
                            err_q      <= 1'b1;
                            err_code_q <= ERR_EMPTY;
                        end else begin
                            // Element 0 was issued this cycle, so the counter resumes at 1.
                            rd_meta_valid_q <= 1'b1;
                            rd_rows_q       <= meta_rows_q[rd_slot];
                            rd_cols_q       <= meta_cols_q[rd_slot];
                            rd_name_q       <= meta_name_q[rd_slot];
                            slot_q          <= rd_slot;
                            total_q         <= rd_total;
                            idx_q           <= CNT_W'(1);
                            state_q         <= issue_last ? ST_RD_DRAIN : ST_RD_STREAM;
                        end
                    end
                end
                ST_WR_STREAM: begin
                    if (wr_fire) begin
                        idx_q <= idx_q + CNT_W'(1);
                        if (idx_q + CNT_W'(1) == total_q) begin
                            wr_ready_q           <= 1'b0;
                            wr_done_q            <= 1'b1;
                            slot_valid_q[slot_q] <= 1'b1;
                            state_q              <= ST_IDLE;
                        end
                    end
                end
                ST_RD_STREAM: begin
                    if (rd_issue) begin
                        idx_q <= idx_q + CNT_W'(1);
                        if (issue_last) begin
                            state_q <= ST_RD_DRAIN;
                        end
                    end
                end
                ST_RD_DRAIN: begin
                    if (pop && rd_last_q) begin
                        rd_done_q <= 1'b1;
                        state_q   <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign wr_ready      = wr_ready_q;
    assign wr_done       = wr_done_q;
    assign rd_meta_valid = rd_meta_valid_q;
    assign rd_rows       = rd_rows_q;
    assign rd_cols       = rd_cols_q;
    assign rd_name       = rd_name_q;
    assign rd_data       = rd_data_q;
    assign rd_valid      = rd_valid_q;
    assign rd_last       = rd_last_q;
    assign rd_done       = rd_done_q;
    assign err           = err_q;
    assign err_code      = err_code_q;
    assign slot_valid    = slot_valid_q;
    assign idle          = is_idle;

endmodule
